// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Optional saturation is enabled by defining ADDSUB_SATURATE_EN.
package alu_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   localparam int MAXW  = 128;
   localparam int DEF_W = 32;
   localparam int DEF_C = 8;

   function automatic int calc_stages(int w, int c);
      return w / c;
   endfunction

   localparam int STAGES = calc_stages(DEF_W, DEF_C);

   function automatic logic [MAXW-1:0] max_pos(int w);
      return (MAXW'(1) << (w - 1)) - MAXW'(1);
   endfunction

   function automatic logic [MAXW-1:0] max_neg(int w);
      return MAXW'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// Carries the sat request when ADDSUB_SATURATE_EN is defined.
interface pipelined_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
`ifdef ADDSUB_SATURATE_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub,
`ifdef ADDSUB_SATURATE_EN
      output sat,
`endif
      output out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub,
`ifdef ADDSUB_SATURATE_EN
      input  sat,
`endif
      input  out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple slice built from fAdder cells.
// Exposes the carry out and the carry into the slice MSB.
module addsub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             cm
);
   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      logic c_in;
      logic c_out;
      if (i == 0) begin : g_lsb
         assign c_in = ci;
      end else begin : g_rip
         assign c_in = g_bit[i-1].c_out;
      end
      fAdder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c_in),
         .s  (s[i]),
         .co (c_out)
      );
   end

   assign co = g_bit[CHUNK-1].c_out;
   assign cm = g_bit[CHUNK-1].c_in;
endmodule

// File: rtl/fAdder.sv
// One-bit full adder, the ripple cell of addsub_chunk.
module fAdder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: one CHUNK slice per stage, carry registered between.
// Define ADDSUB_SATURATE_EN to add signed saturation on request.
module pipelined_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   pipelined_addsub_if.slave bus
);
   localparam int S = calc_stages(WIDTH, CHUNK);
   localparam logic [MAXW-1:0] MP = max_pos(WIDTH);
   localparam logic [MAXW-1:0] MN = max_neg(WIDTH);

   logic [S-1:0] v, adv, cy, pv, pc, co;
   logic         cm, cm_last;
   logic [WIDTH-1:0] opa [S];
   logic [WIDTH-1:0] opb [S];
   logic [WIDTH-1:0] res [S];
   logic [WIDTH-1:0] pa  [S];
   logic [WIDTH-1:0] pb  [S];
   logic [WIDTH-1:0] nr  [S];
   logic [S-1:0][CHUNK-1:0] s;
   logic [WIDTH-1:0] sum_w;
   logic             ovf_w;
   op_t              mode;
`ifdef ADDSUB_SATURATE_EN
   logic [S-1:0] st, ps;
`endif

   assign mode = op_t'(bus.sub);

   // Ready ripples back from the consumer; bubbles collapse.
   always_comb begin
      adv[S-1] = !v[S-1] || bus.out_ready;
      for (int k = S - 2; k >= 0; k--)
         adv[k] = !v[k] || adv[k+1];
   end

   assign bus.in_ready = adv[0];

   always_comb begin
      pv[0] = bus.in_valid;
      pa[0] = bus.a;
      pb[0] = (mode == OP_SUB) ? ~bus.b : bus.b;
      pc[0] = (mode == OP_SUB) | bus.cin;
`ifdef ADDSUB_SATURATE_EN
      ps[0] = bus.sat;
`endif
      for (int k = 1; k < S; k++) begin
         pv[k] = v[k-1];
         pa[k] = opa[k-1];
         pb[k] = opb[k-1];
         pc[k] = cy[k-1];
`ifdef ADDSUB_SATURATE_EN
         ps[k] = st[k-1];
`endif
      end
   end

   always_comb begin
      nr[0] = '0;
      nr[0][CHUNK-1:0] = s[0];
      for (int k = 1; k < S; k++) begin
         nr[k] = res[k-1];
         nr[k][k*CHUNK +: CHUNK] = s[k];
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_stage
      logic cm_k;
      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a  (pa[k][k*CHUNK +: CHUNK]),
         .b  (pb[k][k*CHUNK +: CHUNK]),
         .ci (pc[k]),
         .s  (s[k]),
         .co (co[k]),
         .cm (cm_k)
      );
      if (k == S - 1) begin : g_last
         assign cm_last = cm_k;
      end else begin : g_mid
         logic cm_unused;
         assign cm_unused = cm_k;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v  <= '0;
         cy <= '0;
         cm <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
         st <= '0;
`endif
         for (int k = 0; k < S; k++) begin
            opa[k] <= '0;
            opb[k] <= '0;
            res[k] <= '0;
         end
      end else begin
         for (int k = 0; k < S; k++) begin
            if (adv[k]) begin
               v[k]   <= pv[k];
               opa[k] <= pa[k];
               opb[k] <= pb[k];
               res[k] <= nr[k];
               cy[k]  <= co[k];
`ifdef ADDSUB_SATURATE_EN
               st[k]  <= ps[k];
`endif
            end
         end
         if (adv[S-1])
            cm <= cm_last;
      end
   end

   assign ovf_w = cy[S-1] ^ cm;

`ifdef ADDSUB_SATURATE_EN
   // Overflow implies equal operand signs; A's sign picks the rail.
   always_comb begin
      sum_w = res[S-1];
      if (st[S-1] && ovf_w)
         sum_w = opa[S-1][WIDTH-1] ? MN[WIDTH-1:0] : MP[WIDTH-1:0];
   end
`else
   assign sum_w = res[S-1];
`endif

   assign bus.out_valid = v[S-1];
   assign bus.sum       = sum_w;
   assign bus.cout      = cy[S-1];
   assign bus.ovf       = ovf_w;
   assign bus.zero      = (sum_w == '0);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, CHUNK=8).
// Covers ADDSUB_SATURATE_EN vectors when that macro is defined.
module tb_pipelined_addsub;
   logic clk;
   logic rst_n;

   pipelined_addsub_if #(.WIDTH(32)) bus ();

   pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic        sat;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];
   res_t exq[$];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub,
                                  input logic sat);
      res_t r;
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      longint t;
      t = sub ? sa - sb : sa + sb + longint'(cin);
      r.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      r.sum = t[31:0];
      r.cout = sub ? (a >= b) : ((ua + ub + longint'(cin)) > 64'hFFFFFFFF);
      if (sat && r.ovf)
         r.sum = (t > 0) ? 32'h7FFFFFFF : 32'h80000000;
      r.zero = (r.sum == 32'h0);
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h7FFFFFFF - $urandom_range(0, 3);
         1: return 32'h80000000 + $urandom_range(0, 3);
         2: return $urandom_range(0, 3);
         3: return 32'hFFFFFFFF - $urandom_range(0, 3);
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic sat);
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
      bus.sub = sub;
`ifdef ADDSUB_SATURATE_EN
      bus.sat = sat;
`else
      if (sat) $display("sat request ignored in this build");
`endif
   endtask

   task automatic run_vec(input vec_t t);
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(t.a, t.b, t.cin, t.sub, t.sat);
      bus.in_valid = 1'b1;
      #1;
      chk({t.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({t.name, "_early"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk({t.name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({t.name, "_sum"}, bus.sum, t.sum);
      chk({t.name, "_cout"}, 32'(bus.cout), 32'(t.cout));
      chk({t.name, "_ovf"}, 32'(bus.ovf), 32'(t.ovf));
      chk({t.name, "_zero"}, 32'(bus.zero), 32'(t.zero));
      @(posedge clk);
   endtask

   task automatic add_vec(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic cin,
                          input logic sub, input logic sat,
                          input logic [31:0] sum, input logic cout,
                          input logic ovf, input logic zero);
      vec_t t;
      t.a = a; t.b = b; t.cin = cin; t.sub = sub; t.sat = sat;
      t.sum = sum; t.cout = cout; t.ovf = ovf; t.zero = zero;
      t.name = nm;
      tbl.push_back(t);
   endtask

   task automatic run_stream(input int nops, input bit rnd);
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      bit took = 0;
      logic sat;
      res_t r;
      while (got < nops && cyc < 600) begin
         @(negedge clk);
         if (took) bus.in_valid = 1'b0;
         took = 0;
         bus.out_ready = rnd ? ($urandom_range(0, 3) != 0)
                             : !(cyc >= 5 && cyc <= 7);
         if (!bus.in_valid && sent < nops &&
             (!rnd || $urandom_range(0, 2) != 0)) begin
`ifdef ADDSUB_SATURATE_EN
            sat = 1'($urandom_range(0, 1));
`else
            sat = 1'b0;
`endif
            drive(pick(), pick(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), sat);
            bus.in_valid = 1'b1;
         end
         #1;
         if (!rnd && cyc >= 5 && cyc <= 7)
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         if (bus.out_valid) begin
            if (exq.size() == 0) begin
               chk("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
               chk("stream_sum", bus.sum, exq[0].sum);
               chk("stream_cout", 32'(bus.cout), 32'(exq[0].cout));
               chk("stream_ovf", 32'(bus.ovf), 32'(exq[0].ovf));
               chk("stream_zero", 32'(bus.zero), 32'(exq[0].zero));
               if (bus.out_ready) begin
                  void'(exq.pop_front());
                  got++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
`ifdef ADDSUB_SATURATE_EN
            r = model(bus.a, bus.b, bus.cin, bus.sub, bus.sat);
`else
            r = model(bus.a, bus.b, bus.cin, bus.sub, 1'b0);
`endif
            exq.push_back(r);
            sent++;
            took = 1;
         end
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("stream_count", 32'(got), 32'(nops));
      chk("stream_leftover", 32'(exq.size()), 32'd0);
   endtask

   task automatic reset_mid();
      int stale = 0;
      vec_t t;
      res_t r;
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(pick(), pick(), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_sum", bus.sum, 32'd0);
      chk("rst_mid_zero", 32'(bus.zero), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_rel_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("rst_no_stale", 32'(stale), 32'd0);
      t.a = 32'h12345678; t.b = 32'h0FEDCBA9; t.cin = 1'b1;
      t.sub = 1'b0; t.sat = 1'b0;
      r = model(t.a, t.b, t.cin, t.sub, t.sat);
      t.sum = r.sum; t.cout = r.cout; t.ovf = r.ovf; t.zero = r.zero;
      t.name = "post_reset";
      run_vec(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

      add_vec("ovf_pos", 32'h7FFFFFFF, 32'h1, 0, 0, 0,
              32'h80000000, 0, 1, 0);
      add_vec("sub_neg", 32'h5, 32'h7, 0, 1, 0, 32'hFFFFFFFE, 0, 0, 0);
      add_vec("sub_pos", 32'h7, 32'h5, 0, 1, 0, 32'h2, 1, 0, 0);
      add_vec("wrap_zero", 32'hFFFFFFFF, 32'h0, 1, 0, 0, 32'h0, 1, 0, 1);
      add_vec("sub_cin_ign", 32'hA, 32'hA, 1, 1, 0, 32'h0, 1, 0, 1);
      add_vec("neg_ovf", 32'h80000000, 32'h80000000, 0, 0, 0,
              32'h0, 1, 1, 1);
      add_vec("add_cin", 32'h1, 32'h2, 1, 0, 0, 32'h4, 0, 0, 0);
      add_vec("chunk_carry", 32'h00FFFFFF, 32'h1, 0, 0, 0,
              32'h01000000, 0, 0, 0);
      add_vec("sub_min", 32'h80000000, 32'h1, 0, 1, 0,
              32'h7FFFFFFF, 1, 1, 0);
`ifdef ADDSUB_SATURATE_EN
      add_vec("sat_neg", 32'h80000000, 32'h1, 0, 1, 1,
              32'h80000000, 1, 1, 0);
      add_vec("sat_pos", 32'h7FFFFFFF, 32'h1, 0, 0, 1,
              32'h7FFFFFFF, 0, 1, 0);
      add_vec("sat_noovf", 32'h7, 32'h5, 0, 1, 1, 32'h2, 1, 0, 0);
`endif

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_sum", bus.sum, 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd1);

      for (int i = 0; i < tbl.size(); i++)
         run_vec(tbl[i]);

      run_stream(6, 1'b0);
      run_stream(40, 1'b1);
      reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
